// File: rtl/ets_phase_responder.sv
// Responder side of the ETS dynamic phase-shift handshake: accepts one step request,
// waits a fixed latency, moves the phase index by one position and pulses ps_done.
module ets_phase_responder #(
    parameter int PHASE_STEPS = 448,
    parameter int LATENCY     = 12,
    parameter int PW          = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps_en,
    input  logic          ps_incdec,
    output logic          ps_done,
    output logic          busy,
    output logic [PW-1:0] phase_sel,
    output logic          phase_wrap,
    output logic [15:0]   step_count,
    output logic          err_overrun,
    input  logic          clr_err
);

    if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
        $error("ets_phase_responder: LATENCY must be in 2..255");
    end
    if ((2 ** PW) < PHASE_STEPS) begin : g_bad_pw
        $error("ets_phase_responder: PW too narrow for PHASE_STEPS");
    end

    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASE_STEPS - 1);
    localparam logic [7:0]    CNT_LOAD   = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] phase_sel_q, phase_sel_d;
    logic          phase_wrap_q, phase_wrap_d;
    logic [15:0]   step_count_q, step_count_d;
    logic          err_overrun_q, err_overrun_d;

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] cur, input logic up);
        if (up) begin
            next_phase = (cur == LAST_PHASE) ? '0 : cur + PW'(1);
        end else begin
            next_phase = (cur == '0) ? LAST_PHASE : cur - PW'(1);
        end
    endfunction

    function automatic logic phase_wraps(input logic [PW-1:0] cur, input logic up);
        phase_wraps = up ? (cur == LAST_PHASE) : (cur == '0);
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        phase_sel_d   = phase_sel_q;
        phase_wrap_d  = 1'b0;
        step_count_d  = step_count_q;
        err_overrun_d = err_overrun_q;

        case (state_q)
            S_IDLE: begin
                if (ps_en) begin
                    dir_d   = ps_incdec;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                // Wrap flag is registered on entry to DONE so it lines up with ps_done.
                if (cnt_q == 8'd1) begin
                    state_d      = S_DONE;
                    phase_wrap_d = phase_wraps(phase_sel_q, dir_q);
                end
            end
            S_DONE: begin
                phase_sel_d = next_phase(phase_sel_q, dir_q);
                if (step_count_q != 16'hFFFF) begin
                    step_count_d = step_count_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request while not idle wins over a simultaneous clear.
        if (ps_en && (state_q != S_IDLE)) begin
            err_overrun_d = 1'b1;
        end else if (clr_err) begin
            err_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            phase_sel_q   <= '0;
            phase_wrap_q  <= 1'b0;
            step_count_q  <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            phase_sel_q   <= phase_sel_d;
            phase_wrap_q  <= phase_wrap_d;
            step_count_q  <= step_count_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign ps_done     = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign phase_sel   = phase_sel_q;
    assign phase_wrap  = phase_wrap_q;
    assign step_count  = step_count_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: doc/ets_phase_responder.md
Name: ets_phase_responder

Overview:
- Responder side of the ETS dynamic phase-shift handshake (ps_en / ps_incdec / ps_done).
- Emulates MMCM fine phase-shift timing: accepts one step request, waits a fixed latency, updates a phase index, returns a one-cycle ps_done.
- Drives a phase-select index to a delay/tap stage. Also used as a bench stand-in for the MMCM when simulating the ETS sampler.

Parameters:
- PHASE_STEPS, 448: number of discrete phase positions per full period; the index wraps modulo this value.
- LATENCY, 12: number of cycles from the accepted ps_en cycle to the ps_done cycle. Legal range is 2..255.
- PW, 9: width of phase_sel. Must satisfy 2**PW >= PHASE_STEPS.

Ports:
- clk, input, 1: single clock; also serves as the phase-shift clock.
- reset, input, 1: synchronous, active-high reset.
- ps_en, input, 1: one-cycle step request.
- ps_incdec, input, 1: step direction, sampled with ps_en. 1 = increment, 0 = decrement.
- ps_done, output, 1: one-cycle completion pulse.
- busy, output, 1: high while a step is outstanding.
- phase_sel, output, PW: current phase index, 0..PHASE_STEPS-1.
- phase_wrap, output, 1: one-cycle pulse when the index wraps in either direction.
- step_count, output, 16: number of completed steps; saturates at 16'hFFFF.
- err_overrun, output, 1: sticky flag; set when ps_en arrives while the block is not accepting.
- clr_err, input, 1: clears err_overrun.

Behaviour:
- Reset (synchronous, takes effect at the clock edge where reset=1):
  - state=IDLE; ps_done=0, busy=0, phase_sel=0, phase_wrap=0, step_count=0, err_overrun=0.
  - Reset overrides everything, including a step in flight. No ps_done is produced for an aborted step.
- States:
  - IDLE: busy=0. If ps_en=1, latch dir=ps_incdec, load cnt=LATENCY-1, go to WAIT.
  - WAIT: busy=1, cnt decrements each cycle. When cnt reaches 1, go to DONE.
  - DONE: busy=1 and ps_done=1 for exactly this cycle. Apply the phase update (below), then return to IDLE.
- Latency:
  - If ps_en is high in cycle T, ps_done is high in cycle T+LATENCY.
  - The registered phase_sel shows the new value from cycle T+LATENCY+1.
  - phase_wrap is asserted in the same cycle as ps_done.
  - A new ps_en is accepted at the earliest in cycle T+LATENCY+1.
- Phase update, increment:
  - phase_sel = phase_sel+1.
  - If the old value was PHASE_STEPS-1, phase_sel becomes 0 and phase_wrap pulses.
- Phase update, decrement:
  - phase_sel = phase_sel-1.
  - If the old value was 0, phase_sel becomes PHASE_STEPS-1 and phase_wrap pulses.
- step_count increments by 1 on every ps_done (either direction) and holds at 16'hFFFF.
- Overrun:
  - ps_en while in WAIT or DONE is ignored: no queuing, no effect on dir or cnt.
  - It sets err_overrun=1 on the next edge.
- err_overrun clearing:
  - clr_err=1 clears err_overrun.
  - If clr_err and an overrun occur in the same cycle, set wins and err_overrun stays 1.
- ps_incdec is ignored in every cycle where ps_en is not accepted.
- A ps_en held high for several cycles counts as one accepted request plus overruns for each extra cycle while busy. An edge detector is not inserted.
- Outputs are registered, except ps_done and busy, which may be decoded from state. None of them may glitch combinationally from inputs.

Test Plan:
- Single increment: reset, then a ps_en pulse with ps_incdec=1 at cycle 10.
  - ps_done is high only at cycle 22.
  - busy is high for cycles 11..22.
  - phase_sel reads 1 at cycle 23; step_count=1.
- Decrement wrap: from reset (phase_sel=0), ps_en with ps_incdec=0.
  - At ps_done, phase_wrap=1.
  - phase_sel=447 afterwards.
- Increment wrap: issue 448 back-to-back increments, each ps_en sent one cycle after the previous ps_done.
  - phase_wrap pulses exactly once, on the 448th ps_done.
  - Final phase_sel=0; step_count=448.
- Overrun: ps_en at cycle 10, and again at cycle 15 with ps_incdec=0.
  - Only one ps_done, at cycle 22, and it is an increment (phase_sel=1).
  - err_overrun=1 from cycle 16.
  - clr_err at cycle 30 returns it to 0; asserting clr_err and ps_en-while-busy in the same cycle keeps it at 1.
- Reset mid-step: ps_en at cycle 10, reset at cycle 15.
  - No ps_done ever appears; phase_sel=0, busy=0.
  - A fresh ps_en at cycle 20 completes at cycle 32.
- Parameter corner: LATENCY=2, PHASE_STEPS=4.
  - ps_en at cycle T gives ps_done at T+2.
  - Four increments return phase_sel to 0 with one phase_wrap pulse.
